e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 129 ++++++++++++
 tb/tb_e_mdu.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Multiply/divide unit for the E stage: fixed-latency MULT/MULTU (5 cycles) and
// DIV/DIVU (10 cycles) writing HI/LO, plus MTHI/MTLO writes and MFHI/MFLO reads.
module e_mdu (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic        start,
   input  logic [3:0]  MDUop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] MDU_out
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [3:0]  op_q, op_d;

   logic        is_md, is_mdu, issue_ok, accept;
   logic [63:0] prod_s, prod_u;
   logic        sdiv;
   logic [31:0] abs_a, abs_b, dvd, dvs, qm, rm, quo, rem;

   assign busy      = (state_q != S_IDLE);
   assign is_md     = (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);
   assign is_mdu    = (MDUop >= OP_MULT) && (MDUop <= OP_MTLO);
   assign issue_ok  = start && !busy && !Req;
   assign accept    = issue_ok && is_md;
   assign stall_req = busy || (start && is_mdu);

   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'b0, a_q} * {32'b0, b_q};

   // One unsigned divider serves both flavours; signed divide works on magnitudes
   // and fixes signs afterwards, which also yields 0x80000000/-1 = 0x80000000 r 0.
   assign sdiv  = (op_q == OP_DIV);
   assign abs_a = a_q[31] ? -a_q : a_q;
   assign abs_b = b_q[31] ? -b_q : b_q;
   assign dvd   = sdiv ? abs_a : a_q;
   assign dvs   = (b_q == 32'd0) ? 32'd1 : (sdiv ? abs_b : b_q);
   assign qm    = dvd / dvs;
   assign rm    = dvd % dvs;
   assign quo   = (sdiv && (a_q[31] ^ b_q[31])) ? -qm : qm;
   assign rem   = (sdiv && a_q[31]) ? -rm : rm;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (MDUop <= OP_MULTU) ? S_MUL : S_DIV;
               cnt_d   = (MDUop <= OP_MULTU) ? 4'd4 : 4'd9;
               a_d     = A;
               b_d     = B;
               op_d    = MDUop;
            end else if (issue_ok && MDUop == OP_MTHI) begin
               hi_d = A;
            end else if (issue_ok && MDUop == OP_MTLO) begin
               lo_d = A;
            end
         end
         S_MUL: begin
            if (cnt_q == 4'd0) begin
               state_d      = S_IDLE;
               {hi_d, lo_d} = (op_q == OP_MULT) ? prod_s : prod_u;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DIV: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               if (b_q != 32'd0) begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         op_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      MDU_out = 32'd0;
      if (MDUop == OP_MFHI)      MDU_out = hi_q;
      else if (MDUop == OP_MFLO) MDU_out = lo_q;
   end
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: inputs change on the falling edge, outputs are
// checked shortly after, well away from the rising edge.
module tb_e_mdu;
   logic        clk = 1'b0;
   logic        reset;
   logic        Req, start;
   logic [3:0]  MDUop;
   logic [31:0] A, B;
   logic        busy, stall_req;
   logic [31:0] MDU_out;

   int chk_cnt = 0;
   int err_cnt = 0;
   int n;

   e_mdu dut (
      .clk(clk), .reset(reset), .Req(Req), .start(start), .MDUop(MDUop),
      .A(A), .B(B), .busy(busy), .stall_req(stall_req), .MDU_out(MDU_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present an op for one cycle; returns at the falling edge after the accept edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; MDUop = op; A = a; B = b;
      @(negedge clk);
      start = 1'b0; MDUop = 4'd0; A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D;
   endtask

   // Count falling edges with busy high; bounded so a stuck busy still ends the run.
   task automatic wait_idle(output int cnt);
      cnt = 0;
      #1;
      while (busy && cnt < 30) begin
         cnt++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic rd(input string tag, input logic [3:0] op, input logic [31:0] exp);
      MDUop = op;
      #1;
      chk(tag, MDU_out, exp);
      MDUop = 4'd0;
   endtask

   initial begin
      reset = 1'b1; Req = 1'b0; start = 1'b0; MDUop = 4'd0; A = '0; B = '0;
      #12;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_stall", {31'b0, stall_req}, 32'd0);
      rd("rst_hi", 4'd5, 32'd0);
      rd("rst_lo", 4'd6, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // MULT -2 * 3
      issue(4'd1, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n);
      chk("mult_busy_cycles", n, 5);
      rd("mult_hi", 4'd5, 32'hFFFF_FFFF);
      rd("mult_lo", 4'd6, 32'hFFFF_FFFA);
      rd("other_op_zero", 4'd1, 32'd0);

      // DIV -7 / 2, then DIVU
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      chk("div_busy_cycles", n, 10);
      rd("div_lo", 4'd6, 32'hFFFF_FFFD);
      rd("div_hi", 4'd5, 32'hFFFF_FFFF);
      issue(4'd4, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      chk("divu_busy_cycles", n, 10);
      rd("divu_lo", 4'd6, 32'h7FFF_FFFC);
      rd("divu_hi", 4'd5, 32'd1);

      // MTLO then DIVU by zero leaves HI/LO alone
      @(negedge clk);
      start = 1'b1; MDUop = 4'd8; A = 32'h1234_5678;
      #1 chk("mt_stall", {31'b0, stall_req}, 32'd1);
      @(negedge clk);
      start = 1'b0; MDUop = 4'd0;
      rd("mtlo_lo", 4'd6, 32'h1234_5678);
      issue(4'd4, 32'd55, 32'd0);
      wait_idle(n);
      chk("div0_busy_cycles", n, 10);
      rd("div0_lo", 4'd6, 32'h1234_5678);
      rd("div0_hi", 4'd5, 32'd1);

      // signed overflow case
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      rd("ovf_lo", 4'd6, 32'h8000_0000);
      rd("ovf_hi", 4'd5, 32'd0);

      // Req blocks accept
      @(negedge clk);
      start = 1'b1; MDUop = 4'd1; A = 32'd5; B = 32'd5; Req = 1'b1;
      #1 chk("req_stall", {31'b0, stall_req}, 32'd1);
      @(negedge clk);
      start = 1'b0; MDUop = 4'd0; Req = 1'b0;
      #1 chk("req_busy", {31'b0, busy}, 32'd0);
      chk("req_stall_after", {31'b0, stall_req}, 32'd0);
      rd("req_hi", 4'd5, 32'd0);
      rd("req_lo", 4'd6, 32'h8000_0000);

      // Req in busy cycle 3 does not cancel
      issue(4'd1, 32'h0001_0000, 32'h0001_0000);
      @(negedge clk);
      @(negedge clk);
      Req = 1'b1;
      @(negedge clk);
      Req = 1'b0;
      wait_idle(n);
      chk("req_mid_rest_cycles", n, 2);
      rd("req_mid_hi", 4'd5, 32'd1);
      rd("req_mid_lo", 4'd6, 32'd0);

      // DIVU and MTHI while MULTU busy are ignored
      issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      start = 1'b1; MDUop = 4'd4; A = 32'd100; B = 32'd7;
      #1 chk("busy_stall", {31'b0, stall_req}, 32'd1);
      @(negedge clk);
      MDUop = 4'd7; A = 32'h5555_5555;
      @(negedge clk);
      start = 1'b0; MDUop = 4'd0;
      wait_idle(n);
      chk("ign_rest_cycles", n, 3);
      rd("ign_hi", 4'd5, 32'hFFFF_FFFE);
      rd("ign_lo", 4'd6, 32'h0000_0001);
      @(negedge clk);
      #1 chk("ign_no_restart", {31'b0, busy}, 32'd0);

      // reset in cycle 6 of a DIV
      issue(4'd3, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      #1 chk("pre_rst_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1 chk("arst_busy", {31'b0, busy}, 32'd0);
      rd("arst_hi", 4'd5, 32'd0);
      rd("arst_lo", 4'd6, 32'd0);
      reset = 1'b0;
      issue(4'd1, 32'hFFFF_FFF9, 32'd6);
      wait_idle(n);
      chk("post_rst_cycles", n, 5);
      rd("post_rst_hi", 4'd5, 32'hFFFF_FFFF);
      rd("post_rst_lo", 4'd6, 32'hFFFF_FFD6);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end
endmodule
